// File: rtl/mem_stage_mq_if.sv
// EX/WB/data-SRAM signal bundle for the queued MEM stage.
// The slave modport is the MEM stage; the master modport is its surroundings.
interface mem_stage_mq_if #(
  parameter int PAYLOAD_W = 128,
  parameter int DEPTH     = 4
);
  logic                         flush;
  logic                         es_to_ms_valid;
  logic                         ms_allowin;
  logic [PAYLOAD_W-1:0]         es_to_ms_bus;
  logic                         es_mem_req;
  logic                         es_res_from_mem;
  logic [2:0]                   es_ld_op;
  logic [1:0]                   es_addr_lo;
  logic                         ms_req_allow;
  logic                         ms_to_ws_valid;
  logic                         ws_allowin;
  logic [PAYLOAD_W-1:0]         ms_to_ws_bus;
  logic                         ms_res_from_mem;
  logic [31:0]                  ms_mem_result;
  logic [$clog2(DEPTH+1)-1:0]   ms_occupancy;
  logic                         ms_resp_err;
  logic                         data_sram_data_ok;
  logic [31:0]                  data_sram_rdata;

  modport slave (
    input  flush, es_to_ms_valid, es_to_ms_bus, es_mem_req, es_res_from_mem,
           es_ld_op, es_addr_lo, ws_allowin, data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_req_allow, ms_to_ws_valid, ms_to_ws_bus,
           ms_res_from_mem, ms_mem_result, ms_occupancy, ms_resp_err
  );

  modport master (
    output flush, es_to_ms_valid, es_to_ms_bus, es_mem_req, es_res_from_mem,
           es_ld_op, es_addr_lo, ws_allowin, data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_req_allow, ms_to_ws_valid, ms_to_ws_bus,
           ms_res_from_mem, ms_mem_result, ms_occupancy, ms_resp_err
  );
endinterface

// File: rtl/mem_stage_mq.sv
// Queued MEM stage: in-order entries with several outstanding data requests,
// in-order response matching, load extraction and flush-time response dropping.
module mem_stage_mq #(
  parameter int PAYLOAD_W = 128,
  parameter int DEPTH     = 4,
  parameter int MAX_OUT   = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_stage_mq_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);
  localparam int DW = $clog2(MAX_OUT+1);
  localparam int SW = OW + DW + 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 need;
    logic                 got;
    logic [31:0]          rdata;
    logic                 res;
    logic [2:0]           ld_op;
    logic [1:0]           addr_lo;
  } entry_t;

  entry_t          q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]   head, tail;
  logic [OW-1:0]   occ;
  logic [DW-1:0]   drop_cnt;
  logic            resp_err;

  logic [OW-1:0]   pending;
  logic            fill_found;
  logic [PW-1:0]   fill_idx;
  logic [PW-1:0]   idx;

  // Oldest entry still waiting for data, scanning from head in age order.
  always_comb begin
    pending    = '0;
    fill_found = 1'b0;
    fill_idx   = head;
    idx        = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (vld[idx] && q[idx].need && !q[idx].got) begin
        pending = pending + OW'(1);
        if (!fill_found) begin
          fill_found = 1'b1;
          fill_idx   = idx;
        end
      end
    end
  end

  logic drop_hit, fill_hit, err_hit, head_fill;
  logic push, pop, head_done, allowin;
  entry_t hd;

  assign hd        = q[head];
  assign drop_hit  = bus.data_sram_data_ok && (drop_cnt != '0);
  assign fill_hit  = bus.data_sram_data_ok && !drop_hit && fill_found;
  assign err_hit   = bus.data_sram_data_ok && !drop_hit && !fill_found;
  assign head_fill = fill_hit && (fill_idx == head);

  assign allowin   = occ < OW'(DEPTH);
  assign head_done = (occ != '0) && (!hd.need || hd.got || head_fill);
  assign push      = bus.es_to_ms_valid && allowin && !bus.flush;
  assign pop       = head_done && bus.ws_allowin && !bus.flush;

  // Dropped responses count against the in-flight limit until they return.
  logic [SW-1:0] drop_flush;
  assign drop_flush = SW'(drop_cnt) + SW'(pending) - SW'(fill_hit)
                    + SW'(bus.es_to_ms_valid && bus.es_mem_req) - SW'(drop_hit);

  logic [31:0] word, sh, fmt;
  assign word = head_fill ? bus.data_sram_rdata : hd.rdata;
  assign sh   = word >> {hd.addr_lo, 3'b000};

  always_comb begin
    case (hd.ld_op)
      3'd1:    fmt = {{24{sh[7]}}, sh[7:0]};
      3'd2:    fmt = {24'h0, sh[7:0]};
      3'd3:    fmt = {{16{sh[15]}}, sh[15:0]};
      3'd4:    fmt = {16'h0, sh[15:0]};
      default: fmt = sh;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld      <= '0;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      drop_cnt <= '0;
      resp_err <= 1'b0;
    end else begin
      if (err_hit) resp_err <= 1'b1;
      if (bus.flush) begin
        vld      <= '0;
        head     <= '0;
        tail     <= '0;
        occ      <= '0;
        drop_cnt <= DW'(drop_flush);
      end else begin
        drop_cnt <= drop_cnt - DW'(drop_hit);
        if (push) begin
          vld[tail] <= 1'b1;
          tail      <= tail + PW'(1);
        end
        if (pop) begin
          vld[head] <= 1'b0;
          head      <= head + PW'(1);
        end
        occ <= occ + OW'(push) - OW'(pop);
      end
    end
  end

  // Entry storage needs no reset: every field is qualified by vld.
  always_ff @(posedge clk) begin
    if (fill_hit) begin
      q[fill_idx].got   <= 1'b1;
      q[fill_idx].rdata <= bus.data_sram_rdata;
    end
    if (push) begin
      q[tail].payload <= bus.es_to_ms_bus;
      q[tail].need    <= bus.es_mem_req;
      q[tail].got     <= 1'b0;
      q[tail].rdata   <= '0;
      q[tail].res     <= bus.es_res_from_mem;
      q[tail].ld_op   <= bus.es_ld_op;
      q[tail].addr_lo <= bus.es_addr_lo;
    end
  end

  assign bus.ms_allowin      = allowin;
  assign bus.ms_req_allow    = (SW'(pending) + SW'(drop_cnt)) < SW'(MAX_OUT);
  assign bus.ms_to_ws_valid  = head_done;
  assign bus.ms_to_ws_bus    = hd.payload;
  assign bus.ms_res_from_mem = hd.res;
  assign bus.ms_mem_result   = fmt;
  assign bus.ms_occupancy    = occ;
  assign bus.ms_resp_err     = resp_err;
endmodule

// File: tb/tb_mem_stage_mq.sv
// Scoreboard bench for mem_stage_mq: retirements are checked in order against
// expectations queued at enqueue time; scenario tasks check the rest inline.
module tb_mem_stage_mq;
  localparam int PW    = 128;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_mq_if #(.PAYLOAD_W(PW), .DEPTH(DEPTH)) bus();
  mem_stage_mq #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .MAX_OUT(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  typedef struct {
    logic [PW-1:0] payload;
    logic          res;
    logic [31:0]   result;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sb_on   = 1'b0;

  task automatic idle();
    bus.flush             = 1'b0;
    bus.es_to_ms_valid    = 1'b0;
    bus.es_to_ms_bus      = '0;
    bus.es_mem_req        = 1'b0;
    bus.es_res_from_mem   = 1'b0;
    bus.es_ld_op          = 3'd0;
    bus.es_addr_lo        = 2'd0;
    bus.ws_allowin        = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h0;
  endtask

  task automatic enq(input logic [PW-1:0] p, input logic mreq, input logic res,
                     input logic [2:0] op, input logic [1:0] a, input logic [31:0] er);
    exp_t e;
    bus.es_to_ms_valid  = 1'b1;
    bus.es_to_ms_bus    = p;
    bus.es_mem_req      = mreq;
    bus.es_res_from_mem = res;
    bus.es_ld_op        = op;
    bus.es_addr_lo      = a;
    e.payload = p; e.res = res; e.result = er;
    exp_q.push_back(e);
  endtask

  // Retirement monitor, sampled just before the active edge.
  always begin
    @(negedge clk);
    #4;
    if (sb_on && !reset && bus.ms_to_ws_valid && bus.ws_allowin && !bus.flush) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL retire_unexpected: got payload %0h, expected none", bus.ms_to_ws_bus);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.ms_to_ws_bus !== e.payload || bus.ms_res_from_mem !== e.res ||
            (e.res && bus.ms_mem_result !== e.result)) begin
          n_fail++;
          $display("FAIL retire: got payload %0h res %0b data %08h, expected payload %0h res %0b data %08h",
                   bus.ms_to_ws_bus, bus.ms_res_from_mem, bus.ms_mem_result,
                   e.payload, e.res, e.result);
        end
      end
    end
  end

  task automatic test_reset();
    n_tests++;
    if (bus.ms_allowin !== 1'b1 || bus.ms_req_allow !== 1'b1 || bus.ms_to_ws_valid !== 1'b0 ||
        bus.ms_occupancy !== 3'd0 || bus.ms_resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: allowin %b req_allow %b valid %b occ %0d err %b, expected 1 1 0 0 0",
               bus.ms_allowin, bus.ms_req_allow, bus.ms_to_ws_valid, bus.ms_occupancy, bus.ms_resp_err);
    end
  endtask

  task automatic test_load_bypass(input logic [2:0] op, input logic [31:0] er);
    @(negedge clk); idle(); enq(128'hB0 + PW'(op), 1'b1, 1'b1, op, 2'd2, er);
    @(negedge clk); idle(); bus.ws_allowin = 1'b1; #1;
    n_tests++;
    if (bus.ms_to_ws_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_wait: valid %b, expected 0", bus.ms_to_ws_valid);
    end
    @(negedge clk); idle(); bus.ws_allowin = 1'b1;
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h12803456; #1;
    n_tests++;
    if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_mem_result !== er) begin
      n_fail++;
      $display("FAIL bypass_op%0d: valid %b data %08h, expected 1 %08h", op, bus.ms_to_ws_valid, bus.ms_mem_result, er);
    end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (bus.ms_occupancy !== 3'd0) begin
      n_fail++; $display("FAIL bypass_drain: occ %0d, expected 0", bus.ms_occupancy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    int vi;
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    vi = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); idle(); bus.ws_allowin = 1'b1;
      if (c < 3) enq(128'h300 + PW'(c), 1'b1, 1'b1, 3'd0, 2'd0, vals[c]);
      if (c == 3 || c == 5 || c == 6) begin
        bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = vals[vi]; vi++;
      end
      #1;
      n_tests++;
      if (bus.ms_req_allow !== 1'b1) begin
        n_fail++; $display("FAIL b2b_req_allow c%0d: got %b, expected 1", c, bus.ms_req_allow);
      end
    end
    n_tests++;
    if (bus.ms_occupancy !== 3'd0) begin
      n_fail++; $display("FAIL b2b_drain: occ %0d, expected 0", bus.ms_occupancy);
    end
  endtask

  task automatic test_allowin_full();
    bit done;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); enq(128'h400 + PW'(i), 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
    end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (bus.ms_occupancy !== 3'd4 || bus.ms_allowin !== 1'b0 || bus.ms_to_ws_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full: occ %0d allowin %b valid %b, expected 4 0 1", bus.ms_occupancy, bus.ms_allowin, bus.ms_to_ws_valid);
    end
    bus.ws_allowin = 1'b1; #1;
    n_tests++;
    if (bus.ms_allowin !== 1'b0) begin
      n_fail++; $display("FAIL allowin_comb: got %b, expected 0", bus.ms_allowin);
    end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (bus.ms_occupancy !== 3'd3 || bus.ms_allowin !== 1'b1) begin
      n_fail++; $display("FAIL after_pop: occ %0d allowin %b, expected 3 1", bus.ms_occupancy, bus.ms_allowin);
    end
    bus.ws_allowin = 1'b1; enq(128'h404, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
    @(negedge clk); idle(); #1;
    n_tests++;
    if (bus.ms_occupancy !== 3'd3) begin
      n_fail++; $display("FAIL push_pop: occ %0d, expected 3", bus.ms_occupancy);
    end
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk); idle(); bus.ws_allowin = 1'b1; #1;
      if (bus.ms_occupancy == 3'd0) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL full_drain_timeout: occ %0d, expected 0", bus.ms_occupancy);
    end
  endtask

  task automatic test_flush();
    @(negedge clk); idle(); enq(128'h500, 1'b1, 1'b1, 3'd0, 2'd0, 32'h0);
    @(negedge clk); idle(); enq(128'h501, 1'b1, 1'b1, 3'd0, 2'd0, 32'h0);
    @(negedge clk); idle();
    bus.flush = 1'b1; bus.es_to_ms_valid = 1'b1; bus.es_mem_req = 1'b1; bus.es_res_from_mem = 1'b1;
    exp_q.delete();
    @(negedge clk); idle(); #1;
    n_tests++;
    if (bus.ms_occupancy !== 3'd0 || bus.ms_to_ws_valid !== 1'b0 || bus.ms_req_allow !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_empty: occ %0d valid %b req_allow %b, expected 0 0 1",
               bus.ms_occupancy, bus.ms_to_ws_valid, bus.ms_req_allow);
    end
    enq(128'h510, 1'b1, 1'b1, 3'd3, 2'd2, 32'hFFFF8001);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); idle(); bus.ws_allowin = 1'b1; bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata = (j < 3) ? 32'hDEAD0000 + 32'(j) : 32'h80010000;
      #1;
      if (j == 0) begin
        n_tests++;
        if (bus.ms_req_allow !== 1'b0) begin
          n_fail++; $display("FAIL flush_limit: req_allow %b, expected 0", bus.ms_req_allow);
        end
      end
      if (j == 1) begin
        n_tests++;
        if (bus.ms_req_allow !== 1'b1) begin
          n_fail++; $display("FAIL flush_limit2: req_allow %b, expected 1", bus.ms_req_allow);
        end
      end
      n_tests++;
      if (j < 3 && bus.ms_to_ws_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_drop%0d: valid %b, expected 0", j, bus.ms_to_ws_valid);
      end else if (j == 3 && (bus.ms_to_ws_valid !== 1'b1 || bus.ms_mem_result !== 32'hFFFF8001)) begin
        n_fail++;
        $display("FAIL flush_lh: valid %b data %08h, expected 1 ffff8001", bus.ms_to_ws_valid, bus.ms_mem_result);
      end
    end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (bus.ms_occupancy !== 3'd0) begin
      n_fail++; $display("FAIL flush_drain: occ %0d, expected 0", bus.ms_occupancy);
    end
  endtask

  task automatic test_resp_err();
    @(negedge clk); idle(); #1;
    n_tests++;
    if (bus.ms_resp_err !== 1'b0) begin
      n_fail++; $display("FAIL err_pre: got %b, expected 0", bus.ms_resp_err);
    end
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h1;
    @(negedge clk); idle(); #1;
    n_tests++;
    if (bus.ms_resp_err !== 1'b1 || bus.ms_occupancy !== 3'd0) begin
      n_fail++; $display("FAIL err_set: err %b occ %0d, expected 1 0", bus.ms_resp_err, bus.ms_occupancy);
    end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (bus.ms_resp_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b, expected 1", bus.ms_resp_err);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); idle(); enq(128'h600, 1'b1, 1'b1, 3'd0, 2'd0, 32'h0);
    @(negedge clk); idle(); enq(128'h601, 1'b1, 1'b1, 3'd0, 2'd0, 32'h0);
    @(negedge clk); idle(); bus.flush = 1'b1; exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); enq(128'h610 + PW'(i), 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
    end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (bus.ms_occupancy !== 3'd3 || bus.ms_req_allow !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: occ %0d req_allow %b, expected 3 1", bus.ms_occupancy, bus.ms_req_allow);
    end
    #2 reset = 1'b1; exp_q.delete();
    #1;
    n_tests++;
    if (bus.ms_allowin !== 1'b1 || bus.ms_req_allow !== 1'b1 || bus.ms_to_ws_valid !== 1'b0 ||
        bus.ms_occupancy !== 3'd0 || bus.ms_resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: allowin %b req_allow %b valid %b occ %0d err %b, expected 1 1 0 0 0",
               bus.ms_allowin, bus.ms_req_allow, bus.ms_to_ws_valid, bus.ms_occupancy, bus.ms_resp_err);
    end
    @(negedge clk); reset = 1'b0; idle(); enq(128'h700, 1'b1, 1'b1, 3'd0, 2'd0, 32'h77);
    @(negedge clk); idle(); bus.ws_allowin = 1'b1; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h77; #1;
    n_tests++;
    if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_mem_result !== 32'h77) begin
      n_fail++;
      $display("FAIL post_reset_fill: valid %b data %08h, expected 1 00000077", bus.ms_to_ws_valid, bus.ms_mem_result);
    end
    @(negedge clk); idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #12;
    test_reset();
    @(negedge clk); reset = 1'b0; sb_on = 1'b1;
    test_load_bypass(3'd1, 32'hFFFFFF80);
    test_load_bypass(3'd2, 32'h00000080);
    test_back_to_back();
    test_allowin_full();
    test_flush();
    test_resp_err();
    test_async_reset();
    @(negedge clk); idle(); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_left: %0d entries remain, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_mq.md
Name: mem_stage_mq

Overview:
- Next-generation MEM stage between EX and WB.
- Replaces the single-entry, stall-on-data_ok stage with an in-order queue of DEPTH instructions, so several data-SRAM requests can be outstanding at once.
- Responses are matched to entries in issue order and loaded data is extracted and extended here.
- On flush, responses belonging to cancelled requests are discarded.

Parameters:
PAYLOAD_W, 128, width of the opaque EX->WB payload carried per entry
DEPTH, 4, queue entries (power of two, >=2)
MAX_OUT, 4, maximum data requests in flight, counting both live and dropped

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  exception/eret flush; cancels all queued entries
es_to_ms_valid  in  1  EX holds a valid instruction
ms_allowin  out  1  queue can accept an entry this cycle
es_to_ms_bus  in  PAYLOAD_W  payload, stored unchanged
es_mem_req  in  1  this instruction issued a data request that expects a data_ok
es_res_from_mem  in  1  result is load data
es_ld_op  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW
es_addr_lo  in  2  address bits [1:0]
ms_req_allow  out  1  EX may issue a new data request this cycle
ms_to_ws_valid  out  1  head entry is complete
ws_allowin  in  1  WB accepts
ms_to_ws_bus  out  PAYLOAD_W  head payload
ms_res_from_mem  out  1  head es_res_from_mem
ms_mem_result  out  32  formatted load data of head
ms_occupancy  out  clog2(DEPTH+1)  valid entries
ms_resp_err  out  1  sticky: data_ok arrived with nothing awaiting it
data_sram_data_ok  in  1  in-order response strobe
data_sram_rdata  in  32  response data

Behaviour:
- Reset (async): queue empty, drop_cnt=0, ms_resp_err=0, ms_to_ws_valid=0, ms_allowin=1, ms_req_allow=1, ms_occupancy=0. Reset overrides any cycle in progress; in-flight responses are not tracked after reset.
- Per-entry state: payload, need (es_mem_req), got, rdata, res_from_mem, ld_op, addr_lo.
- Enqueue: when es_to_ms_valid && ms_allowin && !flush, at the tail with got=0.
- Allowin: ms_allowin = occupancy < DEPTH. It is registered-state only; there is no combinational path from ws_allowin. A pop while full frees a slot from the next cycle.
- Request limit: pending = entries with need && !got. ms_req_allow = (pending + drop_cnt) < MAX_OUT.
- Response routing, priority order:
  - drop_cnt > 0: data_ok decrements drop_cnt; the data is discarded.
  - Otherwise: data_ok fills the oldest entry with need && !got (rdata latched, got=1).
  - Otherwise: ms_resp_err is set and no other state changes.
- data_ok never targets the entry being enqueued in the same cycle; the earliest response comes in the cycle after issue.
- Head completion: ms_to_ws_valid = occupancy>0 && (!need || got || data_ok routed to head this cycle). In the routed case ms_mem_result is taken from data_sram_rdata combinationally, giving zero-latency bypass.
- Pop: on ms_to_ws_valid && ws_allowin. Push and pop may both occur in one cycle; occupancy is then unchanged.
- Load format:
  - Shift rdata right by addr_lo*8.
  - LB/LBU take the low byte; LH/LHU take the low half.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - LH/LHU with addr_lo=3 is not checked (alignment is trapped upstream).
  - Non-load heads present alu data through the payload; ms_mem_result is don't-care when ms_res_from_mem=0.
- Flush cycle:
  - Any pop is suppressed, the queue empties, and no enqueue occurs.
  - drop_cnt_next = drop_cnt + (pending entries not filled this cycle) + (es_to_ms_valid && es_mem_req ? 1 : 0) − (data_ok consumed by drop ? 1 : 0).
  - A data_ok arriving in the flush cycle is routed normally first, so it is not double counted.
- Wrap-around: head and tail pointers are DEPTH-modulo.
- drop_cnt cannot exceed MAX_OUT, guaranteed by ms_req_allow.

Test Plan:
- LB, addr_lo=2, rdata 0x12803456, data_ok while the entry is head → same-cycle ms_to_ws_valid=1, ms_mem_result=0xFFFFFF80. The same with LBU → 0x00000080.
- Three LWs enqueued back to back; data_ok with 0xA, 0xB, 0xC on cycles 3, 5, 6; ws_allowin=1 → retire in order with 0xA, 0xB, 0xC; ms_req_allow=1 throughout (3<4).
- Four non-mem entries, ws_allowin=0 → ms_allowin=0 at occupancy 4. Raise ws_allowin for one cycle → occupancy 3 and ms_allowin=1 on the following cycle. Simultaneous push+pop keeps occupancy constant.
- Two pending LWs, flush with EX holding a mem request → queue empties next cycle, drop_cnt=3. A new LH (addr_lo=2) is enqueued, then four data_ok → first three discarded, fourth 0x8001_0000 gives ms_mem_result 0xFFFF8001.
- data_ok with empty queue and drop_cnt=0 → ms_resp_err=1 and stays 1; occupancy unchanged.
- Assert reset mid-stream with 3 entries and drop_cnt=2 → all outputs reach reset values immediately, without waiting for a clock edge.
